// File: rtl/rf_dump_unit.sv
// End-of-run register-file readout: counts cycles after reset, halts the CPU,
// then streams every architectural register out as index/data beats.
module rf_dump_unit #(
   parameter int unsigned END_COUNT  = 100,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  trigger_i,
   output logic                  cpu_halt_o,
   output logic [ADDR_WIDTH-1:0] rf_addr_o,
   input  logic [DATA_WIDTH-1:0] rf_data_i,
   output logic                  dump_valid_o,
   input  logic                  dump_ready_i,
   output logic [ADDR_WIDTH-1:0] dump_idx_o,
   output logic [DATA_WIDTH-1:0] dump_data_o,
   output logic                  dump_done_o
);

   localparam int unsigned CNT_WIDTH = (END_COUNT < 2) ? 1 : $clog2(END_COUNT + 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(END_COUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_COUNT = 3'd0,
      ST_HALT  = 3'd1,
      ST_READ  = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_halt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_dump_idx;
   logic [DATA_WIDTH-1:0] r_dump_data;
   logic                  r_done;

   logic w_count_hit;
   logic w_last_idx;

   assign w_count_hit = (r_cnt == CNT_LAST) || trigger_i;
   assign w_last_idx  = (r_idx == IDX_LAST);

   // Single control process; every output comes straight from a register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= ST_COUNT;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_halt      <= 1'b0;
         r_addr      <= '0;
         r_valid     <= 1'b0;
         r_dump_idx  <= '0;
         r_dump_data <= '0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_COUNT: begin
               r_cnt <= r_cnt + CNT_WIDTH'(1);
               if (w_count_hit) begin
                  r_state <= ST_HALT;
                  r_halt  <= 1'b1;
               end
            end
            // One settle cycle so an RF write issued on the halt edge commits.
            ST_HALT: begin
               r_state <= ST_READ;
               r_idx   <= '0;
               r_addr  <= '0;
            end
            ST_READ: begin
               r_dump_data <= rf_data_i;
               r_dump_idx  <= r_idx;
               r_valid     <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (dump_ready_i) begin
                  r_valid <= 1'b0;
                  if (w_last_idx) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + IDX_ONE;
                     r_addr  <= r_idx + IDX_ONE;
                     r_state <= ST_READ;
                  end
               end
            end
            ST_DONE: begin
               r_halt  <= 1'b1;
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_COUNT;
            end
         endcase
      end
   end

   assign cpu_halt_o   = r_halt;
   assign rf_addr_o    = r_addr;
   assign dump_valid_o = r_valid;
   assign dump_idx_o   = r_dump_idx;
   assign dump_data_o  = r_dump_data;
   assign dump_done_o  = r_done;

endmodule
